// File: rtl/mms_seq_ctrl.sv
// Frame-based running max/min sequencer. It folds N unsigned numbers per frame
// through one shared comparator and holds the result until the consumer takes it.
module mms_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic             sel_r;

  logic             accept;
  logic             last_beat;
  logic             num_gt;
  logic             pick_num;
  logic [WIDTH-1:0] cmp_val;

  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST);

  // One magnitude comparator serves both modes; for min the sense is inverted,
  // and on equality either operand is the same value.
  assign num_gt   = (number > acc);
  assign pick_num = sel_r ? !num_gt : num_gt;
  assign cmp_val  = pick_num ? number : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        busy = 1'b1;
        if (flush) begin
          state_nxt = IDLE;
        end else if (accept && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        in_ready = 1'b0;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      sel_r     <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_r <= select;
            acc   <= number;
            cnt   <= CW'(1);
          end
        end
        ACCUM: begin
          if (flush) begin
            cnt <= '0;
            acc <= '0;
          end else if (accept) begin
            if (last_beat) begin
              result    <= cmp_val;
              out_valid <= 1'b1;
              cnt       <= '0;
            end else begin
              acc <= cmp_val;
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mms_seq_ctrl.sv
// Directed bench for mms_seq_ctrl with hand-computed expected results.
module tb_mms_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic       select;
  logic [7:0] number;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       busy;

  int unsigned errors;
  int unsigned checks;

  mms_seq_ctrl #(.WIDTH(8), .N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .number    (number),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one beat for one edge; returns 1 ns after that edge.
  task automatic send(input logic [7:0] num, input logic sel);
    in_valid = 1'b1;
    number   = num;
    select   = sel;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  logic [7:0] v33 [8];
  logic [7:0] v34 [8];
  logic [7:0] v35 [8];

  initial begin
    v33 = '{8'd3, 8'd200, 8'd17, 8'd200, 8'd0, 8'd99, 8'd255, 8'd4};
    v34 = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd6, 8'd7, 8'd1};
    v35 = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 8'd6, 8'd7, 8'd8};
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    select    = 1'b0;
    number    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_result", result, 0);
    reset = 1'b0;
    idle_cycles(1);

    // Back-to-back max frame
    for (int i = 0; i < 8; i++) begin
      send(v33[i], 1'b0);
      if (i < 7) begin
        check_eq($sformatf("max_busy%0d", i), busy, 1);
        check_eq($sformatf("max_ov%0d", i), out_valid, 0);
      end
    end
    check_eq("max_out_valid", out_valid, 1);
    check_eq("max_result", result, 255);
    check_eq("max_busy_done", busy, 0);
    check_eq("max_in_ready_done", in_ready, 0);
    drain();
    check_eq("max_drain_ov", out_valid, 0);
    check_eq("max_drain_ready", in_ready, 1);

    // Min frame with select toggling and random gaps
    for (int i = 0; i < 8; i++) begin
      send(v34[i], (i == 0) ? 1'b1 : logic'(i % 2 == 0));
      if (i < 7) begin
        check_eq($sformatf("min_ready%0d", i), in_ready, 1);
        idle_cycles($urandom_range(0, 2));
        check_eq($sformatf("min_gap_ready%0d", i), in_ready, 1);
      end
    end
    check_eq("min_out_valid", out_valid, 1);
    check_eq("min_result", result, 1);
    drain();

    // Backpressure: result held while out_ready low; flush in DONE ignored
    for (int i = 0; i < 8; i++) send(v35[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_result%0d", i), result, 40);
      check_eq($sformatf("bp_ready%0d", i), in_ready, 0);
      check_eq($sformatf("bp_ov%0d", i), out_valid, 1);
      if (i == 2) flush = 1'b1;
      idle_cycles(1);
      flush = 1'b0;
    end
    // Beat offered together with out_ready must not be taken
    in_valid  = 1'b1;
    number    = 8'd77;
    select    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_release_ov", out_valid, 0);
    check_eq("bp_release_busy", busy, 0);
    check_eq("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_next_frame_busy", busy, 1);
    for (int i = 0; i < 7; i++) send(8'd1, 1'b0);
    check_eq("bp_next_result", result, 77);
    drain();

    // Flush after 4 beats, with a dropped beat in the flush cycle
    for (int i = 0; i < 4; i++) send(8'd200, 1'b0);
    flush = 1'b1;
    send(8'd250, 1'b0);
    flush = 1'b0;
    check_eq("flush_busy", busy, 0);
    check_eq("flush_ov", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      send(8'd50, 1'b1);
      if (i < 7) check_eq($sformatf("flush_ov%0d", i), out_valid, 0);
    end
    check_eq("flush_out_valid", out_valid, 1);
    check_eq("flush_result", result, 50);
    drain();

    // Asynchronous reset between edges mid-frame
    for (int i = 0; i < 5; i++) send(8'd9, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ready", in_ready, 1);
    check_eq("arst_ov", out_valid, 0);
    check_eq("arst_result", result, 0);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      send(8'h80, 1'b0);
      if (i < 7) check_eq($sformatf("arst_ov%0d", i), out_valid, 0);
    end
    check_eq("arst_out_valid", out_valid, 1);
    check_eq("arst_result_frame", result, 8'h80);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
